// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, helpers and payload types for the VGA output path.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned C_W   = 4;

  typedef struct packed {
    logic [C_W-1:0] r;
    logic [C_W-1:0] g;
    logic [C_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Pin level for a sync signal given whether it is asserted and its active level.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-coordinate / colour bus between the raster timing block and the colour-generation stage.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [X_W-1:0] oVGA_X;
  logic [Y_W-1:0] oVGA_Y;
  logic [C_W-1:0] iRed;
  logic [C_W-1:0] iGreen;
  logic [C_W-1:0] iBlue;

  modport master (output oVGA_X, output oVGA_Y, input iRed, input iGreen, input iBlue);
  modport slave  (input oVGA_X, input oVGA_Y, output iRed, output iGreen, output iBlue);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear to a chosen idle value.
module vga_delay_line #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             iVGA_CLK,
  input  logic             iRST_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) r_stage <= {DEPTH{RST_VAL}};
      else         r_stage <= i_d;
    end
  end else begin : g_many
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) r_stage <= {DEPTH{RST_VAL}};
      else         r_stage <= {r_stage[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_out.sv
// VGA raster counters, sync/DE generation delayed to match the colour stage, and the registered DAC output.
module vga_timing_out
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned PIPE_DLY = 1,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic           iVGA_CLK,
  input  logic           iRST_n,
  input  logic           iEnable,
  vga_timing_if.master   io_pix,
  output logic [C_W-1:0] oVGA_R,
  output logic [C_W-1:0] oVGA_G,
  output logic [C_W-1:0] oVGA_B,
  output logic           oVGA_HS,
  output logic           oVGA_VS,
  output logic           oVGA_DE,
  output logic           oFrame_Start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam sync_t       SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0};

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  sync_t            r_sync;
  rgb_t             r_rgb;
  logic             r_frame_start;

  logic  w_h_wrap;
  logic  w_v_wrap;
  logic  w_h_act;
  logic  w_v_act;
  logic  w_hs_on;
  logic  w_vs_on;
  sync_t w_sync_raw;
  sync_t w_sync_dly;
  rgb_t  w_rgb_in;

  assign w_h_wrap = (r_h_cnt == CNT_W'(H_TOTAL - 1));
  assign w_v_wrap = (r_v_cnt == CNT_W'(V_TOTAL - 1));
  assign w_h_act  = (r_h_cnt < CNT_W'(H_ACTIVE));
  assign w_v_act  = (r_v_cnt < CNT_W'(V_ACTIVE));

  // Raster counters; v only moves on the h wrap, so vsync never changes mid-line.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!iEnable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_hs_on = iEnable && (r_h_cnt >= CNT_W'(HS_START)) && (r_h_cnt <= CNT_W'(HS_END));
  assign w_vs_on = iEnable && (r_v_cnt >= CNT_W'(VS_START)) && (r_v_cnt <= CNT_W'(VS_END));

  assign w_sync_raw = '{hs: sync_level(w_hs_on, SYNC_POL),
                        vs: sync_level(w_vs_on, SYNC_POL),
                        de: iEnable && w_h_act && w_v_act};

  // Coordinates go straight out so the colour stage sees the current counter position.
  assign io_pix.oVGA_X = w_h_act ? X_W'(r_h_cnt) : '0;
  assign io_pix.oVGA_Y = w_v_act ? r_v_cnt[Y_W-1:0] : '0;

  vga_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .i_d      (w_sync_raw),
    .o_q      (w_sync_dly)
  );

  assign w_rgb_in = '{r: io_pix.iRed, g: io_pix.iGreen, b: io_pix.iBlue};

  // Pin register: colour returning from the colour stage lines up with the delayed DE here.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_sync        <= SYNC_IDLE;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_sync        <= w_sync_dly;
      r_rgb         <= w_sync_dly.de ? w_rgb_in : '0;
      r_frame_start <= iEnable && (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  assign oVGA_R       = r_rgb.r;
  assign oVGA_G       = r_rgb.g;
  assign oVGA_B       = r_rgb.b;
  assign oVGA_HS      = r_sync.hs;
  assign oVGA_VS      = r_sync.vs;
  assign oVGA_DE      = r_sync.de;
  assign oFrame_Start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: a reduced-geometry instance under a cycle scoreboard plus a full 640x480 instance for line timing.
module tb_vga_timing_out;

  localparam int T_H_ACT  = 16;
  localparam int T_H_FP   = 2;
  localparam int T_H_SYNC = 4;
  localparam int T_H_BP   = 3;
  localparam int T_V_ACT  = 6;
  localparam int T_V_FP   = 2;
  localparam int T_V_SYNC = 2;
  localparam int T_V_BP   = 3;
  // Hand-derived from the geometry above: 25 clocks per line, 13 lines per frame.
  localparam int T_H_TOT  = 25;
  localparam int T_V_TOT  = 13;
  localparam int T_HS_LO  = 18;
  localparam int T_HS_HI  = 21;
  localparam int T_VS_LO  = 8;
  localparam int T_VS_HI  = 9;
  localparam int SETTLE   = 2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pin_t;

  typedef struct {
    bit en;
    bit solid;
    int cycles;
    int de_n;
    int hs_lo;
    int vs_lo;
    int fs_n;
    int r_nz;
  } seg_t;

  localparam pin_t PIN_IDLE = '{r: 4'd0, g: 4'd0, b: 4'd0, hs: 1'b1, vs: 1'b1, de: 1'b0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;
  bit   solid = 1'b1;

  logic [3:0] d_r, d_g, d_b, f_r, f_g, f_b;
  logic       d_hs, d_vs, d_de, d_fs, f_hs, f_vs, f_de, f_fs;

  vga_timing_if u_pix ();
  vga_timing_if u_pix_full ();

  vga_timing_out #(
    .H_ACTIVE (T_H_ACT), .H_FP (T_H_FP), .H_SYNC (T_H_SYNC), .H_BP (T_H_BP),
    .V_ACTIVE (T_V_ACT), .V_FP (T_V_FP), .V_SYNC (T_V_SYNC), .V_BP (T_V_BP),
    .PIPE_DLY (1), .SYNC_POL (1'b0)
  ) u_dut (
    .iVGA_CLK (clk), .iRST_n (rst_n), .iEnable (en), .io_pix (u_pix),
    .oVGA_R (d_r), .oVGA_G (d_g), .oVGA_B (d_b),
    .oVGA_HS (d_hs), .oVGA_VS (d_vs), .oVGA_DE (d_de), .oFrame_Start (d_fs)
  );

  vga_timing_out u_full (
    .iVGA_CLK (clk), .iRST_n (rst_n), .iEnable (en), .io_pix (u_pix_full),
    .oVGA_R (f_r), .oVGA_G (f_g), .oVGA_B (f_b),
    .oVGA_HS (f_hs), .oVGA_VS (f_vs), .oVGA_DE (f_de), .oFrame_Start (f_fs)
  );

  always #5 clk = ~clk;

  // Colour stage model: one register stage fed from the coordinates.
  always @(posedge clk) begin
    u_pix.iRed   <= solid ? 4'hF : u_pix.oVGA_X[3:0];
    u_pix.iGreen <= solid ? 4'hF : ~u_pix.oVGA_X[3:0];
    u_pix.iBlue  <= solid ? 4'hF : u_pix.oVGA_Y[3:0];
  end

  assign u_pix_full.iRed   = 4'hF;
  assign u_pix_full.iGreen = 4'hF;
  assign u_pix_full.iBlue  = 4'hF;

  int   n_checks = 0;
  int   n_errors = 0;
  int   mh = 0;
  int   mv = 0;
  bit   exp_fs = 1'b0;
  pin_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic pin_t model_pins(input int h, input int v, input bit e, input bit s);
    pin_t       p;
    logic [3:0] xl;
    logic [3:0] yl;
    bit         de;
    de   = e && (h < T_H_ACT) && (v < T_V_ACT);
    xl   = (h < T_H_ACT) ? 4'(h) : 4'd0;
    yl   = (v < T_V_ACT) ? 4'(v) : 4'd0;
    p.de = de;
    p.hs = !(e && h >= T_HS_LO && h <= T_HS_HI);
    p.vs = !(e && v >= T_VS_LO && v <= T_VS_HI);
    p.r  = de ? (s ? 4'hF : xl)  : 4'h0;
    p.g  = de ? (s ? 4'hF : ~xl) : 4'h0;
    p.b  = de ? (s ? 4'hF : yl)  : 4'h0;
    return p;
  endfunction

  function automatic pin_t dut_pins();
    return {d_r, d_g, d_b, d_hs, d_vs, d_de};
  endfunction

  function automatic pin_t full_pins();
    return {f_r, f_g, f_b, f_hs, f_vs, f_de};
  endfunction

  task automatic sample();
    pin_t e;
    check("x", int'(u_pix.oVGA_X), (mh < T_H_ACT) ? mh : 0);
    check("y", int'(u_pix.oVGA_Y), (mv < T_V_ACT) ? mv : 0);
    check("frame_start", int'(d_fs), int'(exp_fs));
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("pins", int'(dut_pins()), int'(e));
    end
  endtask

  // Drive the inputs for the coming clock and queue the pins they should produce two clocks later.
  task automatic step_in(input bit e, input bit s);
    en    = e;
    solid = s;
    exp_q.push_back(model_pins(mh, mv, e, s));
    exp_fs = e && (mh == 0) && (mv == 0);
    if (!e) begin
      mh = 0;
      mv = 0;
    end else if (mh == T_H_TOT - 1) begin
      mh = 0;
      mv = (mv == T_V_TOT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic tick(input bit e, input bit s);
    @(posedge clk);
    @(negedge clk);
    sample();
    step_in(e, s);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pins"}, int'(dut_pins()), int'(PIN_IDLE));
    check({tag, "_x"}, int'(u_pix.oVGA_X), 0);
    check({tag, "_y"}, int'(u_pix.oVGA_Y), 0);
    check({tag, "_fs"}, int'(d_fs), 0);
    check({tag, "_full_pins"}, int'(full_pins()), int'(PIN_IDLE));
    check({tag, "_full_xy"}, int'({u_pix_full.oVGA_X, u_pix_full.oVGA_Y}), 0);
    check({tag, "_full_fs"}, int'(f_fs), 0);
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    mh    = 0;
    mv    = 0;
    exp_q.delete();
    exp_q.push_back(PIN_IDLE);
    step_in(1'b1, solid);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("arst");
    repeat (3) begin
      @(negedge clk);
      check_idle("arst_hold");
    end
    release_rst();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    seg_t segs[4];
    int   first_fall, second_fall, hs_low, de_n, vs_low, rgb_bad, guard;
    int   c_de, c_hs, c_vs, c_fs, c_r;
    bit   prev_hs;

    segs[0] = '{en: 1'b1, solid: 1'b0, cycles: 325, de_n: 96,  hs_lo: 52,  vs_lo: 50,  fs_n: 1, r_nz: 90};
    segs[1] = '{en: 1'b1, solid: 1'b1, cycles: 650, de_n: 192, hs_lo: 104, vs_lo: 100, fs_n: 2, r_nz: 192};
    segs[2] = '{en: 1'b0, solid: 1'b1, cycles: 40,  de_n: 0,   hs_lo: 0,   vs_lo: 0,   fs_n: 0, r_nz: 0};
    segs[3] = '{en: 1'b1, solid: 1'b0, cycles: 325, de_n: 96,  hs_lo: 52,  vs_lo: 50,  fs_n: 1, r_nz: 90};

    // Reset held with colour inputs saturated.
    repeat (5) begin
      @(negedge clk);
      check_idle("rst");
    end
    release_rst();

    // Full-size line timing, measured from the release edge.
    first_fall = -1; second_fall = -1; hs_low = 0; de_n = 0; vs_low = 0; rgb_bad = 0;
    prev_hs = 1'b1;
    for (int i = 1; i <= 1700; i++) begin
      tick(1'b1, 1'b1);
      if (prev_hs && !f_hs) begin
        if (first_fall < 0) first_fall = i;
        else if (second_fall < 0) second_fall = i;
      end
      if (!f_hs && i < 1000) hs_low++;
      if (f_de && i < 800) de_n++;
      if (!f_vs) vs_low++;
      if ((f_de && f_r != 4'hF) || (!f_de && f_r != 4'h0)) rgb_bad++;
      if (i == 10)  check("full_x_active", int'(u_pix_full.oVGA_X), 10);
      if (i == 700) check("full_x_hblank", int'(u_pix_full.oVGA_X), 0);
      prev_hs = f_hs;
    end
    check("full_hs_first_fall", first_fall, 658);
    check("full_hs_period", second_fall - first_fall, 800);
    check("full_hs_width", hs_low, 96);
    check("full_de_per_line", de_n, 640);
    check("full_vs_quiet", vs_low, 0);
    check("full_rgb_blanking", rgb_bad, 0);

    // Whole-frame event counts on the reduced geometry.
    foreach (segs[s]) begin
      c_de = 0; c_hs = 0; c_vs = 0; c_fs = 0; c_r = 0;
      for (int k = 0; k < SETTLE + segs[s].cycles; k++) begin
        tick(segs[s].en, segs[s].solid);
        if (k >= SETTLE) begin
          c_de += int'(d_de);
          c_hs += int'(!d_hs);
          c_vs += int'(!d_vs);
          c_fs += int'(d_fs);
          c_r  += int'(d_r != 4'h0);
        end
      end
      check($sformatf("seg%0d_de", s), c_de, segs[s].de_n);
      check($sformatf("seg%0d_hs_low", s), c_hs, segs[s].hs_lo);
      check($sformatf("seg%0d_vs_low", s), c_vs, segs[s].vs_lo);
      check($sformatf("seg%0d_frame_start", s), c_fs, segs[s].fs_n);
      check($sformatf("seg%0d_red_nonzero", s), c_r, segs[s].r_nz);
    end

    // Drop enable mid-frame at (10,3) for 10 clocks.
    guard = 0;
    while (!(mh == 10 && mv == 3) && guard < 500) begin
      tick(1'b1, 1'b0);
      guard++;
    end
    check("en_reach_pos", int'(mh == 10 && mv == 3), 1);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0);
      if (k == 2) begin
        check("dis_de", int'(d_de), 0);
        check("dis_red", int'(d_r), 0);
        check("dis_xy", int'({u_pix.oVGA_X, u_pix.oVGA_Y}), 0);
      end
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("reen_fs", int'(d_fs), 1);
    check("reen_x", int'(u_pix.oVGA_X), 1);
    check("reen_y", int'(u_pix.oVGA_Y), 0);
    repeat (60) tick(1'b1, 1'b0);

    // Asynchronous reset pulse mid-frame at (10,4).
    guard = 0;
    while (!(mh == 10 && mv == 4) && guard < 500) begin
      tick(1'b1, 1'b0);
      guard++;
    end
    check("arst_reach_pos", int'(mh == 10 && mv == 4), 1);
    async_reset();
    tick(1'b1, 1'b0);
    check("arst_fs", int'(d_fs), 1);
    check("arst_x", int'(u_pix.oVGA_X), 1);
    check("arst_y", int'(u_pix.oVGA_Y), 0);
    repeat (400) tick(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
